// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for serial_word_loader.
// Contents: the FSM state width and the state encoding. The same encoding
// appears in the legacy loader_defs.vh, so it stays visible in waveforms.
package serial_word_loader_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_SHIFT = 3'd1;
    localparam logic [STATE_W-1:0] S_LOAD  = 3'd2;
    localparam logic [STATE_W-1:0] S_PAR   = 3'd3;
    localparam logic [STATE_W-1:0] S_ERR   = 3'd4;

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// bit_counter: counts the data bits taken in the current frame.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous reset, active-low
//   clr  in   synchronous clear to 0
//   en   in   increment by one
//   tc   out  terminal count, high while count == WIDTH-1
// The counter is $clog2(WIDTH) bits wide. When tc is high, the next enabled
// bit is the last data bit of the word.
module bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst)      cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_loader.sv
// serial_word_loader: builds a WIDTH-bit word from a qualified serial
// stream. It presents the word on word_out together with a one-cycle
// load_en pulse for the downstream load register.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-low
//   start      in   frame start strobe; honoured only in IDLE
//   ser_in     in   serial data bit
//   ser_valid  in   ser_in qualifier; sampled only while shifting or in parity
//   word_out   out  last good word; holds until the next load
//   load_en    out  one-cycle pulse, changes on the same edge as word_out
//   busy       out  high while a frame is in progress
//   par_err    out  one-cycle pulse on a parity mismatch
// Build option: LOADER_PARITY_CHECK_EN
//   When defined, one even-parity bit follows the WIDTH data bits.
//   When undefined, there is no parity bit and par_err is tied low.
// Parameters:
//   WIDTH      word width, at least 2
//   LSB_FIRST  1: the first received bit ends up in word_out[0]
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             load_en,
    output logic             busy,
    output logic             par_err
);

    logic [STATE_W-1:0] state;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]   sr_nxt;
    logic               take;
    logic               tc;

    assign take = (state == S_SHIFT) && ser_valid;

    // LSB-first order shifts right. Each new bit enters at the MSB, so the
    // first bit reaches bit 0 after WIDTH shifts.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign sr_nxt = {ser_in, sr[WIDTH-1:1]};
        end else begin : g_msb
            assign sr_nxt = {sr[WIDTH-2:0], ser_in};
        end
    endgenerate

    // The counter is held clear in IDLE, so every frame starts at count 0.
    bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == S_IDLE),
        .en  (take),
        .tc  (tc)
    );

`ifndef LOADER_PARITY_CHECK_EN
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            sr       <= '0;
            word_out <= '0;
            load_en  <= 1'b0;
            busy     <= 1'b0;
`ifdef LOADER_PARITY_CHECK_EN
            par_err  <= 1'b0;
`endif
        end else begin
            load_en <= 1'b0;
`ifdef LOADER_PARITY_CHECK_EN
            par_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SHIFT;
                        sr    <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (ser_valid) begin
                        sr <= sr_nxt;
                        if (tc) begin
`ifdef LOADER_PARITY_CHECK_EN
                            state <= S_PAR;
`else
                            // The word is published on the same edge that takes its last bit.
                            state    <= S_LOAD;
                            word_out <= sr_nxt;
                            load_en  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LOADER_PARITY_CHECK_EN
                S_PAR: begin
                    if (ser_valid) begin
                        // Even parity: the XOR over the data and parity bits must be 0.
                        if ((^sr) ^ ser_in) begin
                            state   <= S_ERR;
                            par_err <= 1'b1;
                        end else begin
                            state    <= S_LOAD;
                            word_out <= sr;
                            load_en  <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
`endif
                S_LOAD: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed testbench for serial_word_loader with WIDTH=4. Instance u_a uses
// LSB_FIRST=1 and instance u_b uses LSB_FIRST=0. Both get the same stimulus.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_serial_word_loader;

    localparam int W = 4;
`ifdef LOADER_PARITY_CHECK_EN
    localparam int PERIOD = W + 3;
`else
    localparam int PERIOD = W + 2;
`endif

    logic         clk, rst, start, ser_in, ser_valid;
    logic [W-1:0] word_a, word_b;
    logic         load_a, load_b, busy_a, busy_b, perr_a, perr_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nload = 0;
    int last_load = 0;
    int prev_load = 0;
    int snap;

    serial_word_loader #(.WIDTH(W), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .ser_valid(ser_valid),
        .word_out(word_a), .load_en(load_a), .busy(busy_a), .par_err(perr_a));

    serial_word_loader #(.WIDTH(W), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .ser_valid(ser_valid),
        .word_out(word_b), .load_en(load_b), .busy(busy_b), .par_err(perr_b));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Counts load pulses on u_a and records the cycle number of the last two.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_a) begin
            nload     <= nload + 1;
            prev_load <= last_load;
            last_load <= cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // Checks both instances. The LSB-first word is w, sent in the order
    // w[0] first. The other instance is expected to hold the bit reversal of w.
    task automatic chk_out(input string tag, input logic [W-1:0] w, input logic ld,
                           input logic bz, input logic pe);
        chk({tag, ".word_a"}, 32'(word_a), 32'(w));
        chk({tag, ".word_b"}, 32'(word_b), 32'(rev(w)));
        chk({tag, ".load_a"}, 32'(load_a), 32'(ld));
        chk({tag, ".load_b"}, 32'(load_b), 32'(ld));
        chk({tag, ".busy_a"}, 32'(busy_a), 32'(bz));
        chk({tag, ".busy_b"}, 32'(busy_b), 32'(bz));
        chk({tag, ".perr_a"}, 32'(perr_a), 32'(pe));
        chk({tag, ".perr_b"}, 32'(perr_b), 32'(pe));
    endtask

    // Sends start, then bits b[0]..b[W-1]. An idle gap of gap_len cycles is
    // inserted before bit gap_at. When spam is set, start stays high through
    // the frame. bad_par flips the parity bit. The task returns on the falling
    // edge just after the last bit is taken.
    task automatic send_frame(input logic [W-1:0] b, input int gap_at, input int gap_len,
                              input bit spam, input bit bad_par);
        start = 1'b1;
        tick();
        for (int i = 0; i < W; i++) begin
            start = spam;
            if (i == gap_at) begin
                ser_valid = 1'b0;
                ser_in    = ~b[i];
                for (int g = 0; g < gap_len; g++) begin
                    chk("gap.load", 32'(load_a | load_b), 32'd0);
                    tick();
                end
            end
            ser_valid = 1'b1;
            ser_in    = b[i];
            chk("early.load", 32'(load_a | load_b), 32'd0);
            chk("mid.busy", 32'(busy_a), 32'd1);
            tick();
        end
`ifdef LOADER_PARITY_CHECK_EN
        ser_in = (^b) ^ bad_par;
        chk("prepar.load", 32'(load_a | load_b), 32'd0);
        tick();
`else
        chk("nopar.flag", 32'(bad_par), 32'd0);
`endif
        ser_valid = 1'b0;
        start     = 1'b0;
        ser_in    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
        tick(); tick();
        chk_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // Bits 1,0,1,0 with no gaps.
        snap = nload;
        send_frame(4'b0101, -1, 0, 1'b0, 1'b0);
        chk_out("t1", 4'b0101, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t1.idle", 4'b0101, 1'b0, 1'b0, 1'b0);
        chk("t1.pulses", 32'(nload - snap), 32'd1);

        // Bits 1,0,0,1 with two invalid cycles between the 2nd and 3rd bits.
        snap = nload;
        send_frame(4'b1001, 2, 2, 1'b0, 1'b0);
        chk_out("t2", 4'b1001, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t2.idle", 4'b1001, 1'b0, 1'b0, 1'b0);
        chk("t2.pulses", 32'(nload - snap), 32'd1);

        // Reset after two bits: the partial frame is discarded, then a full 1111 frame.
        snap = nload;
        start = 1'b1; tick();
        start = 1'b0; ser_valid = 1'b1; ser_in = 1'b1; tick();
        ser_in = 1'b0; tick();
        rst = 1'b0; ser_valid = 1'b0;
        tick();
        chk_out("t3.rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk("t3.nopulse", 32'(nload - snap), 32'd0);
        send_frame(4'b1111, -1, 0, 1'b0, 1'b0);
        chk_out("t3", 4'b1111, 1'b1, 1'b1, 1'b0);
        tick();

        // Back-to-back frames, each start at the earliest legal edge.
        send_frame(4'b0101, -1, 0, 1'b0, 1'b0);
        chk_out("b2b.1", 4'b0101, 1'b1, 1'b1, 1'b0);
        tick();
        send_frame(4'b1001, -1, 0, 1'b0, 1'b0);
        chk_out("b2b.2", 4'b1001, 1'b1, 1'b1, 1'b0);
        tick();
        chk("b2b.period", 32'(last_load - prev_load), 32'(PERIOD));

        // Start held high during SHIFT has no effect; result matches the first frame.
        snap = nload;
        send_frame(4'b0101, -1, 0, 1'b1, 1'b0);
        chk_out("t4", 4'b0101, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t4.idle", 4'b0101, 1'b0, 1'b0, 1'b0);
        chk("t4.pulses", 32'(nload - snap), 32'd1);

`ifdef LOADER_PARITY_CHECK_EN
        // Good parity, then a bad-parity frame with different data bits.
        send_frame(4'b0101, -1, 0, 1'b0, 1'b0);
        chk_out("pgood", 4'b0101, 1'b1, 1'b1, 1'b0);
        tick();
        snap = nload;
        send_frame(4'b0110, -1, 0, 1'b0, 1'b1);
        chk_out("pbad", 4'b0101, 1'b0, 1'b1, 1'b1);
        tick();
        chk_out("pbad.idle", 4'b0101, 1'b0, 1'b0, 1'b0);
        chk("pbad.pulses", 32'(nload - snap), 32'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
